// File: rtl/dcache_direct.sv
// Blocking direct-mapped, write-through, no-write-allocate data cache between the
// MEM-stage data port and data memory; 4-word lines refilled over a req/ack port.
module dcache_direct #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_req,
   input  logic [3:0]  cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = LINES * 4;
   localparam int TAG_BITS = 28 - INDEX_BITS;

   typedef enum logic [2:0] {IDLE, REFILL, UNC_RD, WRITE, RESP} state_t;

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [31:0]         data_q [WORDS];
   logic [31:0]         resp_q;
   logic [31:0]         hitCnt_q;
   logic [31:0]         missCnt_q;

   logic [TAG_BITS-1:0]   reqTag;
   logic [INDEX_BITS-1:0] reqIdx;
   logic [1:0]            reqOff;
   logic                  cacheable;
   logic                  hit;
   logic                  isWrite;
   logic [31:0]           lineWord;
   logic                  unusedAddrBits;

   logic readyRaw;
   logic refillWe;
   logic storeHit;
   logic hitInc;
   logic missInc;
   logic lineFill;
   logic lineInval;
   logic respLoad;

   assign reqTag         = cpu_addr[31:INDEX_BITS+4];
   assign reqIdx         = cpu_addr[INDEX_BITS+3:4];
   assign reqOff         = cpu_addr[3:2];
   assign unusedAddrBits = ^cpu_addr[1:0];
   assign cacheable      = (cpu_addr[31:29] != 3'b101);
   assign hit            = valid_q[reqIdx] & (tag_q[reqIdx] == reqTag) & cacheable;
   assign isWrite        = |cpu_wen;
   assign lineWord       = data_q[{reqIdx, reqOff}];

   // Cacheable accesses always answer from the line; uncached reads from the latched word.
   assign cpu_rdata = cacheable ? lineWord : resp_q;
   assign cpu_ready = readyRaw & resetn;
   assign hit_cnt   = hitCnt_q;
   assign miss_cnt  = missCnt_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      readyRaw  = 1'b0;
      mem_req   = 1'b0;
      mem_wen   = 4'b0000;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      refillWe  = 1'b0;
      storeHit  = 1'b0;
      hitInc    = 1'b0;
      missInc   = 1'b0;
      lineFill  = 1'b0;
      lineInval = 1'b0;
      respLoad  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               if (isWrite) begin
                  storeHit = hit;
                  state_d  = WRITE;
               end else if (hit) begin
                  readyRaw = 1'b1;
                  hitInc   = 1'b1;
               end else if (cacheable) begin
                  missInc   = 1'b1;
                  lineInval = 1'b1;
                  cnt_d     = 2'd0;
                  state_d   = REFILL;
               end else begin
                  state_d = UNC_RD;
               end
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {reqTag, reqIdx, cnt_q, 2'b00};
            if (mem_ack) begin
               refillWe = 1'b1;
               cnt_d    = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  lineFill = 1'b1;
                  state_d  = RESP;
               end
            end
         end
         UNC_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               respLoad = 1'b1;
               state_d  = RESP;
            end
         end
         WRITE: begin
            mem_req = 1'b1;
            mem_wen = cpu_wen;
            if (mem_ack) begin
               state_d = RESP;
            end
         end
         RESP: begin
            readyRaw = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state and counters; the line being refilled is invalid until its last beat.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= 2'd0;
         valid_q   <= '0;
         hitCnt_q  <= 32'd0;
         missCnt_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hitInc) begin
            hitCnt_q <= hitCnt_q + 32'd1;
         end
         if (missInc) begin
            missCnt_q <= missCnt_q + 32'd1;
         end
         if (lineInval) begin
            valid_q[reqIdx] <= 1'b0;
         end
         if (lineFill) begin
            valid_q[reqIdx] <= 1'b1;
         end
      end
   end

   // Tag/data storage is never cleared; only the valid bits decide what is usable.
   always_ff @(posedge clk) begin
      if (resetn) begin
         if (refillWe) begin
            data_q[{reqIdx, cnt_q}] <= mem_rdata;
         end else if (storeHit) begin
            for (int b = 0; b < 4; b++) begin
               if (cpu_wen[b]) begin
                  data_q[{reqIdx, reqOff}][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
               end
            end
         end
         if (lineFill) begin
            tag_q[reqIdx] <= reqTag;
         end
         if (respLoad) begin
            resp_q <= mem_rdata;
         end
      end
   end

endmodule
